// File: rtl/hello_world_nios2_qsys_oci_dct_packer.sv
// rtl/hello_world_nios2_qsys_oci_dct_packer.sv - packs 2-bit OCI trace atoms into 15-atom DCT frames
// Optional idle flush of partial frames: define OCI_DCT_IDLE_FLUSH_EN.
module hello_world_nios2_qsys_oci_dct_packer #(
  parameter int IDLE_LIMIT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        atom_valid,
  input  logic [1:0]  atom_data,
  output logic        atom_ready,
  input  logic        test_end_req,
  input  logic        dct_ready,
  output logic        dct_valid,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        test_ending,
  output logic        test_has_ended
);

  typedef enum logic [1:0] {FILL, FLUSH, ENDED} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [29:0] acc;
  logic [3:0]  acc_cnt;
  logic        slot_free;
  logic        accept;
  logic        transfer;
  logic        idle_req;

  assign slot_free  = !dct_valid || dct_ready;
  assign atom_ready = (state == FILL) && ((acc_cnt != 4'd15) || slot_free);
  assign accept     = atom_valid && atom_ready;
  assign transfer   = slot_free &&
                      ((acc_cnt == 4'd15) ||
                       (((state == FLUSH) || idle_req) && (acc_cnt != 4'd0)));

`ifdef OCI_DCT_IDLE_FLUSH_EN
  logic [15:0] idle_cnt;

  // Counter saturates at the limit so a held slot cannot wrap it past the request.
  assign idle_req = (state == FILL) && (idle_cnt >= 16'(IDLE_LIMIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= 16'd0;
    end else if (accept || transfer) begin
      idle_cnt <= 16'd0;
    end else if ((state == FILL) && (acc_cnt != 4'd0) && !idle_req) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end
`else
  assign idle_req = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (test_end_req) state_nxt = FLUSH;
      FLUSH:   if ((acc_cnt == 4'd0) && !dct_valid) state_nxt = ENDED;
      ENDED:   state_nxt = ENDED;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FILL;
      acc        <= 30'd0;
      acc_cnt    <= 4'd0;
      dct_valid  <= 1'b0;
      dct_buffer <= 30'd0;
      dct_count  <= 4'd0;
    end else begin
      state <= state_nxt;
      if (transfer) begin
        dct_buffer <= acc;
        dct_count  <= acc_cnt;
        dct_valid  <= 1'b1;
        // An atom arriving with the transfer opens the next frame at slot 0.
        if (accept) begin
          acc     <= {28'd0, atom_data};
          acc_cnt <= 4'd1;
        end else begin
          acc     <= 30'd0;
          acc_cnt <= 4'd0;
        end
      end else begin
        if (dct_ready) dct_valid <= 1'b0;
        if (accept) begin
          acc[{acc_cnt, 1'b0} +: 2] <= atom_data;
          acc_cnt                   <= acc_cnt + 4'd1;
        end
      end
    end
  end

  assign test_ending    = (state == FLUSH);
  assign test_has_ended = (state == ENDED);

endmodule

// File: tb/tb_hello_world_nios2_qsys_oci_dct_packer.sv
// tb/tb_hello_world_nios2_qsys_oci_dct_packer.sv - randomized bench with queue-based frame model
module tb_hello_world_nios2_qsys_oci_dct_packer;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        atom_valid = 1'b0;
  logic [1:0]  atom_data = 2'd0;
  logic        atom_ready;
  logic        test_end_req = 1'b0;
  logic        dct_ready = 1'b0;
  logic        dct_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: atoms not yet framed, the output slot, and a phase 0=fill 1=flush 2=ended.
  logic [1:0]  pend[$];
  bit          m_valid;
  logic [29:0] m_buf;
  logic [3:0]  m_cnt;
  int          ph;
  int          icnt;
  bit          last_acc;
  int          frames;

  hello_world_nios2_qsys_oci_dct_packer #(.IDLE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .atom_valid(atom_valid), .atom_data(atom_data),
    .atom_ready(atom_ready), .test_end_req(test_end_req), .dct_ready(dct_ready),
    .dct_valid(dct_valid), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_valid = 0; m_buf = '0; m_cnt = '0; ph = 0; icnt = 0;
  endtask

  task automatic check_outputs(input bit r);
    bit exp_rdy;
    exp_rdy = (ph == 0) && (pend.size() != 15 || !m_valid || r);
    chk("atom_ready", {31'd0, atom_ready}, {31'd0, exp_rdy});
    chk("dct_valid", {31'd0, dct_valid}, {31'd0, m_valid});
    chk("dct_count", {28'd0, dct_count}, {28'd0, m_cnt});
    chk("dct_buffer", {2'd0, dct_buffer}, {2'd0, m_buf});
    chk("test_ending", {31'd0, test_ending}, (ph == 1) ? 32'd1 : 32'd0);
    chk("test_has_ended", {31'd0, test_has_ended}, (ph == 2) ? 32'd1 : 32'd0);
  endtask

  task automatic cycle(input bit v, input logic [1:0] d, input bit te, input bit r);
    bit sf, rdy_m, acc, ireq, xfer, old_valid;
    int n;
    @(negedge clk);
    atom_valid = v; atom_data = d; test_end_req = te; dct_ready = r;
    #1;
    check_outputs(r);
    @(posedge clk);
    n = pend.size();
    old_valid = m_valid;
    sf = !m_valid || r;
    rdy_m = (ph == 0) && (n != 15 || sf);
    acc = v && rdy_m;
    ireq = 0;
`ifdef OCI_DCT_IDLE_FLUSH_EN
    ireq = (ph == 0) && (icnt >= LIM);
`endif
    xfer = sf && (n == 15 || ((ph == 1 || ireq) && n != 0));
    if (xfer) begin
      m_buf = '0;
      for (int i = 0; i < n; i++) m_buf[2*i +: 2] = pend[i];
      m_cnt = 4'(n);
      m_valid = 1;
      pend.delete();
      frames++;
    end else if (r) begin
      m_valid = 0;
    end
    if (acc) pend.push_back(d);
    if (acc || xfer) icnt = 0;
    else if (ph == 0 && n != 0) icnt++;
    if (ph == 0 && te) ph = 1;
    else if (ph == 1 && n == 0 && !old_valid) ph = 2;
    last_acc = acc;
  endtask

  // Reset is raised between edges so its effect must be visible with no clock.
  task automatic do_reset();
    @(negedge clk);
    atom_valid = 0; test_end_req = 0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs(dct_ready);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_n(input int cnt, input bit r);
    int sent = 0;
    for (int k = 0; k < cnt * 4 + 8 && sent < cnt; k++) begin
      cycle(1, 2'($urandom), 0, r);
      if (last_acc) sent++;
    end
    chk("send_n_accepted", sent, cnt);
  endtask

  initial begin
    model_reset();
    frames = 0;
    #1;
    check_outputs(0);
    do_reset();

    // single frame, counting pattern
    for (int i = 0; i < 15; i++) cycle(1, 2'(i % 4), 0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
    chk("single_frames", frames, 1);

    // backpressure: 31 atoms with the slot held for a while
    begin
      int sent = 0;
      for (int k = 0; k < 120 && sent < 31; k++) begin
        cycle(1, 2'($urandom), 0, k >= 40);
        if (last_acc) sent++;
      end
      chk("bp_accepted", sent, 31);
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);
    end

    // random streaming
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, 2'($urandom), 0, $urandom_range(0, 2) != 0);

    // flush: 7 atoms, then end request with an atom in the same cycle
    do_reset();
    frames = 0;
    send_n(7, 1);
    cycle(1, 2'($urandom), 1, 1);
    for (int k = 0; k < 20 && ph != 2; k++) cycle(1, 2'($urandom), 0, $urandom_range(0, 1));
    for (int i = 0; i < 3; i++) cycle(1, 2'($urandom), 1, 1);
    chk("flush_frames", frames, 1);
    chk("flush_count", {28'd0, m_cnt}, 32'd8);
    chk("flush_ended", {31'd0, test_has_ended}, 32'd1);

    // reset mid-frame with the slot held
    do_reset();
    send_n(15, 0);
    send_n(9, 0);
    do_reset();
    frames = 0;
    send_n(15, 1);
    cycle(0, 0, 0, 1);
    chk("post_reset_frames", frames, 1);

`ifdef OCI_DCT_IDLE_FLUSH_EN
    do_reset();
    frames = 0;
    send_n(3, 1);
    for (int i = 0; i < LIM + 3; i++) cycle(0, 0, 0, 1);
    chk("idle_frames", frames, 1);
`else
    do_reset();
    frames = 0;
    send_n(3, 1);
    for (int i = 0; i < 80; i++) cycle(0, 0, 0, 1);
    chk("no_idle_frames", frames, 0);
`endif

    // random runs including end requests
    for (int run = 0; run < 3; run++) begin
      do_reset();
      for (int i = 0; i < 250; i++)
        cycle($urandom_range(0, 4) != 0, 2'($urandom), $urandom_range(0, 90) == 0,
              $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
